vga_sync_gen: RTL and testbench

//  640x480@60 VGA timing generator, directly downstream of the 25 MHz pixel-clock divider.
//  - Samples the divider's clk25MHz output in the clk100MHz domain and derives a one-cycle pixel_tick.
//  - Runs the horizontal and vertical counters on that tick.
//  - Drives hsync/vsync to the connector and video_on/pixel_x/pixel_y to the image renderer.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_sync_gen_if.sv | 30 +++
 rtl/vga_sync_gen_pix_tick_detect.sv | 29 ++
 rtl/vga_sync_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_gen.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   640x480@60 timing constants shared by the VGA sync generator, its
//   interface and its sub-module.
//   Contents: raw porch/sync widths, derived totals and sync windows,
//   and the 10-bit coordinate type used for pixel_x/pixel_y.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam bit SYNC_POL = 1'b0;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if
//   Output bundle of the VGA sync generator.
//   master: driven by vga_sync_gen; slave: connector / image renderer side.
//   Signals: pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y,
//   frame_start, and frame_cnt[15:0] only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   pixel_tick;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (output pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y,
                  frame_start, frame_cnt);
  modport slave  (input  pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y,
                  frame_start, frame_cnt);
`else
  modport master (output pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y,
                  frame_start);
  modport slave  (input  pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y,
                  frame_start);
`endif

endinterface

// File: rtl/vga_sync_gen_pix_tick_detect.sv
// pix_tick_detect
//   Turns the divider's clk25MHz (a data signal in the clk100MHz domain)
//   into a registered one-cycle pixel_tick on each rising edge.
//   Ports: clk100MHz, reset (async, active-high), clk25MHz in;
//          pixel_tick out.
module pix_tick_detect
  import vga_timing_pkg::*;
(
  input  logic clk100MHz,
  input  logic reset,
  input  logic clk25MHz,
  output logic pixel_tick
);

  logic clk25_d;

  // clk25_d clears on reset, so a divider already high at release
  // produces a tick on the first cycle.
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      clk25_d    <= 1'b0;
      pixel_tick <= 1'b0;
    end else begin
      clk25_d    <= clk25MHz;
      pixel_tick <= clk25MHz & ~clk25_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   640x480@60 VGA timing generator fed by the 25 MHz pixel-clock divider.
//   Counts pixels/lines on pixel_tick and decodes sync, blanking and
//   position outputs, all registered with one clk100MHz of latency.
//   Ports: clk100MHz, reset (async, active-high), clk25MHz in;
//          vga (vga_sync_gen_if.master) carrying all outputs.
//   Optional: define VGA_FRAME_CNT_EN to add the 16-bit frame counter.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic           clk100MHz,
  input  logic           reset,
  input  logic           clk25MHz,
  vga_sync_gen_if.master vga
);

  localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic   pixel_tick;
  coord_t h_cnt;
  coord_t v_cnt;
  logic   frame_wrap;

  pix_tick_detect u_tick (
    .clk100MHz  (clk100MHz),
    .reset      (reset),
    .clk25MHz   (clk25MHz),
    .pixel_tick (pixel_tick)
  );

  // frame_wrap marks the cycle after the counters wrap to (0,0), so the
  // decode stage can issue frame_start alongside the (0,0) outputs.
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      frame_wrap <= 1'b0;
    end else begin
      frame_wrap <= pixel_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      if (pixel_tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  logic   hsync_q;
  logic   vsync_q;
  logic   video_on_q;
  coord_t pixel_x_q;
  coord_t pixel_y_q;
  logic   frame_start_q;

  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      video_on_q    <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      pixel_x_q     <= h_cnt;
      pixel_y_q     <= v_cnt;
      frame_start_q <= frame_wrap;
    end
  end

  assign vga.pixel_tick  = pixel_tick;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.pixel_x     = pixel_x_q;
  assign vga.pixel_y     = pixel_y_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Advances on the same edge that raises frame_start; wraps naturally.
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Scoreboard bench for vga_sync_gen. Horizontal timing is the real
//   800-tick line; the vertical timing is shortened to 8 lines
//   (4 active, 1 FP, 2 sync, 1 BP) so whole frames fit in a short run.
module tb_vga_sync_gen;

  localparam int HT     = 800;
  localparam int VT     = 8;
  localparam int HS_LO  = 656;
  localparam int HS_HI  = 751;
  localparam int VS_LO  = 5;
  localparam int VS_HI  = 6;
  localparam int H_VIS  = 640;
  localparam int V_VIS  = 4;
  localparam int FRAME  = HT * VT;

  logic clk100MHz = 1'b0;
  logic reset     = 1'b1;
  logic clk25MHz  = 1'b0;

  vga_sync_gen_if vga ();

  vga_sync_gen #(
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1)
  ) dut (
    .clk100MHz (clk100MHz),
    .reset     (reset),
    .clk25MHz  (clk25MHz),
    .vga       (vga)
  );

  always #5 clk100MHz = ~clk100MHz;

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic von;
    logic fs;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_tick = 0;
  bit mon_en = 1'b0;

  int cyc = 0;
  int last_tick = -1;
  int last_fall = -1;
  int tick_total = 0;
  int ev_cnt = 0;
  int von_ev = 0;
  int hs_low_ev = 0;
  int vs_low_ev = 0;
  int fs_ev = 0;
  int fs_cycles = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int n);
    exp_t e;
    e.x   = n % HT;
    e.y   = (n / HT) % VT;
    e.hs  = (e.x >= HS_LO && e.x <= HS_HI) ? 1'b0 : 1'b1;
    e.vs  = (e.y >= VS_LO && e.y <= VS_HI) ? 1'b0 : 1'b1;
    e.von = (e.x < H_VIS) && (e.y < V_VIS);
    e.fs  = (e.x == 0) && (e.y == 0);
    q.push_back(e);
  endtask

  // One divider period: low for two cycles, high for two.
  task automatic drive_tick();
    @(negedge clk100MHz) clk25MHz = 1'b0;
    @(negedge clk100MHz);
    @(negedge clk100MHz);
    clk25MHz = 1'b1;
    n_tick++;
    push_exp(n_tick);
    @(negedge clk100MHz);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pixel_x"},     int'(vga.pixel_x),     0);
    check({tag, "_pixel_y"},     int'(vga.pixel_y),     0);
    check({tag, "_hsync"},       int'(vga.hsync),       1);
    check({tag, "_vsync"},       int'(vga.vsync),       1);
    check({tag, "_video_on"},    int'(vga.video_on),    0);
    check({tag, "_pixel_tick"},  int'(vga.pixel_tick),  0);
    check({tag, "_frame_start"}, int'(vga.frame_start), 0);
  endtask

  task automatic check_released(input string tag);
    check({tag, "_pixel_x"},     int'(vga.pixel_x),     0);
    check({tag, "_pixel_y"},     int'(vga.pixel_y),     0);
    check({tag, "_video_on"},    int'(vga.video_on),    1);
    check({tag, "_hsync"},       int'(vga.hsync),       1);
    check({tag, "_frame_start"}, int'(vga.frame_start), 0);
  endtask

  // Monitor: every change of position is one output update to score.
  initial begin : monitor
    int   prev_x;
    int   prev_y;
    logic prev_hs;
    exp_t e;
    prev_x  = 0;
    prev_y  = 0;
    prev_hs = 1'b1;
    forever begin
      @(negedge clk100MHz);
      cyc++;
      if (vga.pixel_tick) tick_total++;
      if (mon_en) begin
        if (vga.pixel_tick) begin
          if (last_tick >= 0) check("tick_spacing", cyc - last_tick, 4);
          last_tick = cyc;
        end
        if (int'(vga.pixel_x) != prev_x || int'(vga.pixel_y) != prev_y) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_update: got (%0d,%0d) with nothing expected",
                     vga.pixel_x, vga.pixel_y);
          end else begin
            e = q.pop_front();
            if (int'(vga.pixel_x) != e.x || int'(vga.pixel_y) != e.y ||
                vga.hsync != e.hs || vga.vsync != e.vs ||
                vga.video_on != e.von || vga.frame_start != e.fs) begin
              n_bad++;
              $display("FAIL pos_update: got x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b, expected x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b",
                       vga.pixel_x, vga.pixel_y, vga.hsync, vga.vsync, vga.video_on,
                       vga.frame_start, e.x, e.y, e.hs, e.vs, e.von, e.fs);
            end
          end
          ev_cnt++;
          if (ev_cnt <= FRAME) begin
            if (vga.video_on)    von_ev++;
            if (!vga.hsync)      hs_low_ev++;
            if (!vga.vsync)      vs_low_ev++;
            if (vga.frame_start) fs_ev++;
          end
        end
        if (vga.frame_start) fs_cycles++;
        if (prev_hs && !vga.hsync) begin
          check("hsync_start_x", int'(vga.pixel_x), HS_LO);
          if (last_fall >= 0) check("line_period", cyc - last_fall, 3200);
          last_fall = cyc;
        end
        if (!prev_hs && vga.hsync && last_fall >= 0)
          check("hsync_width", cyc - last_fall, 384);
      end
      prev_x  = int'(vga.pixel_x);
      prev_y  = int'(vga.pixel_y);
      prev_hs = vga.hsync;
    end
  end

  initial begin : stimulus
    int t0;
    reset    = 1'b1;
    clk25MHz = 1'b0;
    repeat (3) @(negedge clk100MHz);
    check_reset_vals("reset");

    reset = 1'b0;
    @(negedge clk100MHz);
    check_released("release");

    // Just over one full frame, ending on (300,2).
    n_tick = 0;
    mon_en = 1'b1;
    repeat (FRAME + 2 * HT + 300) drive_tick();
    clk25MHz = 1'b0;
    repeat (4) @(negedge clk100MHz);
    check("queue_drained", q.size(), 0);
    check("updates_seen", ev_cnt, FRAME + 2 * HT + 300);
    check("at_300_x", int'(vga.pixel_x), 300);
    check("at_300_y", int'(vga.pixel_y), 2);
    check("active_ticks", von_ev, 2560);
    check("hsync_low_ticks", hs_low_ev, 768);
    check("vsync_low_ticks", vs_low_ev, 1600);
    check("frame_start_updates", fs_ev, 1);
    check("frame_start_cycles", fs_cycles, 1);
`ifdef VGA_FRAME_CNT_EN
    check("frame_cnt_one", int'(vga.frame_cnt), 1);
`endif

    // Asynchronous reset mid-frame, between clock edges.
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset");
`ifdef VGA_FRAME_CNT_EN
    check("frame_cnt_reset", int'(vga.frame_cnt), 0);
`endif
    @(negedge clk100MHz);
    @(negedge clk100MHz) reset = 1'b0;
    @(negedge clk100MHz);
    check_released("rerelease");

    last_tick = -1;
    last_fall = -1;
    n_tick    = 0;
    mon_en    = 1'b1;
    repeat (20) drive_tick();
    clk25MHz = 1'b0;
    repeat (4) @(negedge clk100MHz);
    check("queue_drained_2", q.size(), 0);
    check("restart_x", int'(vga.pixel_x), 20);
    check("restart_y", int'(vga.pixel_y), 0);
    check("no_fs_after_reset", fs_cycles, 1);

    // Divider stalled low: no ticks, counters frozen.
    t0 = tick_total;
    repeat (100) @(negedge clk100MHz);
    check("stall_ticks", tick_total - t0, 0);
    check("stall_x", int'(vga.pixel_x), 20);
    check("stall_y", int'(vga.pixel_y), 0);
    check("stall_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
